// File: rtl/csa_pkg.sv
// Shared types and defaults for the carry-save packet accumulator.
package csa_pkg;

  localparam int CSA_DEFAULT_WIDTH = 64;
  localparam int CSA_DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACC     = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_OUT     = 2'd3
  } csa_state_e;

endpackage

// File: rtl/csa_row.sv
// One 3:2 carry-save row: sum, carry shifted into weight position, and the
// carry bit that falls off the top.
module csa_row #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             cout
);

  logic [WIDTH-1:0] maj;

  always_comb begin
    maj   = (a & b) | (a & c) | (b & c);
    sum   = a ^ b ^ c;
    carry = {maj[WIDTH-2:0], 1'b0};
    cout  = maj[WIDTH-1];
  end

endmodule

// File: rtl/csa_accum.sv
// Packet accumulator: operands fold into a carry-save pair, one resolve cycle
// performs the carry-propagate add, and the result is held until taken.
module csa_accum
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_DEFAULT_WIDTH,
  parameter int CNT_W = CSA_DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  csa_state_e       state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d, c_q, c_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             xfer;
  logic             first;
  logic [WIDTH-1:0] row_s_in, row_c_in, row_sum, row_carry;
  logic             row_cout;
  logic [WIDTH:0]   resolve_add;

  // IDLE presents a zero pair so the first operand loads straight into S.
  always_comb begin
    first    = (state_q == ST_IDLE);
    row_s_in = first ? '0 : s_q;
    row_c_in = first ? '0 : c_q;
  end

  csa_row #(.WIDTH(WIDTH)) u_row (
    .a     (row_s_in),
    .b     (row_c_in),
    .c     (in_data),
    .sum   (row_sum),
    .carry (row_carry),
    .cout  (row_cout)
  );

  always_comb begin
    in_ready  = ((state_q == ST_IDLE) || (state_q == ST_ACC)) && !clr;
    out_valid = (state_q == ST_OUT);
    xfer      = in_valid && in_ready;
    out_sum   = sum_q;
    out_count = cnt_q;
    out_ovf   = ovf_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ACC: if (xfer) state_d = in_last ? ST_RESOLVE : ST_ACC;
      ST_RESOLVE:      state_d = ST_OUT;
      ST_OUT:          if (out_ready) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
    if (clr) state_d = ST_IDLE;
  end

  always_comb begin
    s_d         = s_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    sum_d       = sum_q;
    resolve_add = {1'b0, s_q} + {1'b0, c_q};
    if (clr) begin
      s_d   = '0;
      c_d   = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      sum_d = '0;
    end else if (xfer) begin
      s_d   = row_sum;
      c_d   = row_carry;
      cnt_d = first ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
      ovf_d = (first ? 1'b0 : ovf_q) | row_cout;
    end else if (state_q == ST_RESOLVE) begin
      sum_d = resolve_add[WIDTH-1:0];
      ovf_d = ovf_q | resolve_add[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_csa_accum.sv
// Bench for csa_accum: packet-level reference model checked every cycle,
// directed scenarios with literal results, and a narrow-counter instance.
module tb_csa_accum;
  localparam int W  = 64;
  localparam int CW = 16;
  localparam int BW = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clr, in_valid, in_last, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid, out_ovf;
  logic [W-1:0]  out_sum;
  logic [CW-1:0] out_count;

  logic          b_clr, b_in_valid, b_in_last, b_out_ready;
  logic [BW-1:0] b_in_data;
  logic          b_in_ready, b_out_valid, b_out_ovf;
  logic [BW-1:0] b_out_sum;
  logic [BC-1:0] b_out_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit model_on = 1'b0;

  csa_accum #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  csa_accum #(.WIDTH(BW), .CNT_W(BC)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_count(b_out_count), .out_ovf(b_out_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: packet sum as plain arithmetic, result visible two cycles after the last transfer.
  initial begin
    logic [W-1:0] m_sum;
    logic [W:0]   t;
    int           m_cnt;
    bit           m_ovf, m_acc, m_res, m_out, exp_rdy;
    m_sum = '0; m_cnt = 0; m_ovf = 0; m_acc = 0; m_res = 0; m_out = 0;
    wait (model_on);
    forever begin
      @(negedge clk);
      exp_rdy = !m_res && !m_out && !clr;
      chk("model_in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("model_out_valid", 64'(out_valid), 64'(m_out));
      if (m_out) begin
        chk("model_out_sum", out_sum, m_sum);
        chk("model_out_count", 64'(out_count), 64'(m_cnt));
        chk("model_out_ovf", 64'(out_ovf), 64'(m_ovf));
      end
      if (!rst_n || clr) begin
        m_acc = 0; m_res = 0; m_out = 0;
      end else if (m_out) begin
        if (out_ready) m_out = 0;
      end else if (m_res) begin
        m_res = 0; m_out = 1;
      end else if (in_valid) begin
        if (!m_acc) begin
          m_sum = in_data; m_cnt = 1; m_ovf = 0;
        end else begin
          t     = {1'b0, m_sum} + {1'b0, in_data};
          m_sum = t[W-1:0];
          m_ovf = m_ovf | t[W];
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        m_acc = !in_last;
        m_res = in_last;
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit last);
    int k = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 50) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: in_ready stuck low, expected 1");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_b(input logic [BW-1:0] d, input bit last);
    int k = 0;
    b_in_valid = 1'b1; b_in_data = d; b_in_last = last;
    forever begin
      @(negedge clk);
      if (b_in_ready) break;
      k++;
      if (k > 50) begin
        n_tests++; n_fail++;
        $display("FAIL send_b_timeout: in_ready stuck low, expected 1");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  function automatic logic [W-1:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(0, 255));
      1:       return {32'hFFFF_FFFF, $urandom()};
      2:       return '1;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; clr = 0; in_valid = 0; in_last = 0; in_data = '0; out_ready = 1;
    b_clr = 0; b_in_valid = 0; b_in_last = 0; b_in_data = '0; b_out_ready = 1;
    @(posedge clk); #1;
    model_on = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_sum", out_sum, 64'd0);
    chk("reset_out_count", 64'(out_count), 64'd0);
    chk("reset_out_ovf", 64'(out_ovf), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // 5,7,9: result two cycles after the last transfer
    send(5, 0); send(7, 0); send(9, 1);
    @(negedge clk);
    chk("lat_resolve_valid", 64'(out_valid), 64'd0);
    chk("lat_resolve_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("p579_sum", out_sum, 64'd21);
    chk("p579_count", 64'(out_count), 64'd3);
    chk("p579_ovf", 64'(out_ovf), 64'd0);
    @(posedge clk); #1;

    send('1, 1);
    @(negedge clk); @(negedge clk);
    chk("max_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("max_count", 64'(out_count), 64'd1);
    chk("max_ovf", 64'(out_ovf), 64'd0);
    @(posedge clk); #1;
    send('1, 0); send(1, 1);
    @(negedge clk); @(negedge clk);
    chk("wrap_sum", out_sum, 64'd0);
    chk("wrap_count", 64'(out_count), 64'd2);
    chk("wrap_ovf", 64'(out_ovf), 64'd1);
    @(posedge clk); #1;

    // Backpressure: result must hold while out_ready is low
    out_ready = 0;
    send(3, 0); send(4, 1);
    @(negedge clk); @(negedge clk);
    chk("hold_valid_first", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_sum", out_sum, 64'd7);
      chk("hold_count", 64'(out_count), 64'd2);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hs_idle_valid", 64'(out_valid), 64'd0);
    chk("hs_idle_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // clr beats a simultaneous operand
    send(1, 0); send(2, 0);
    in_valid = 1; in_data = 3; in_last = 0; clr = 1;
    @(negedge clk);
    chk("clr_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    clr = 0; in_valid = 0;
    @(negedge clk);
    chk("clr_idle_ready", 64'(in_ready), 64'd1);
    chk("clr_idle_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send(6, 1);
    @(negedge clk); @(negedge clk);
    chk("after_clr_sum", out_sum, 64'd6);
    chk("after_clr_count", 64'(out_count), 64'd1);
    @(posedge clk); #1;

    // Reset while resolving drops the result
    send(2, 1);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_resolve_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(2, 0); send(2, 1);
    @(negedge clk); @(negedge clk);
    chk("post_rst_sum", out_sum, 64'd4);
    chk("post_rst_count", 64'(out_count), 64'd2);
    @(posedge clk); #1;

    // Narrow instance: count saturates at 3, 8-bit wrap sets ovf
    for (int i = 0; i < 5; i++) send_b(1, i == 4);
    @(negedge clk); @(negedge clk);
    chk("b_sat_valid", 64'(b_out_valid), 64'd1);
    chk("b_sat_sum", 64'(b_out_sum), 64'd5);
    chk("b_sat_count", 64'(b_out_count), 64'd3);
    chk("b_sat_ovf", 64'(b_out_ovf), 64'd0);
    @(posedge clk); #1;
    send_b(200, 0); send_b(100, 1);
    @(negedge clk); @(negedge clk);
    chk("b_ovf_sum", 64'(b_out_sum), 64'd44);
    chk("b_ovf_count", 64'(b_out_count), 64'd2);
    chk("b_ovf_ovf", 64'(b_out_ovf), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = pick_data();
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 59) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      @(posedge clk); #1;
    end
    in_valid = 0; clr = 0; rst_n = 1; out_ready = 1;
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
